// File: rtl/grf_writeback_sink_if.sv
// Writeback / register-read / commit-trace bundle for grf_writeback_sink.
//   master: W stage + D stage + trace consumer side (drives writeback, read
//           addresses and trace_ready; receives read data and trace head).
//   slave : the register file itself.
// Signals:
//   RegWrite_W, WriteReg_W, Result_W, PC_W : W-stage writeback bundle
//   RA1/RA2 -> RD1/RD2                     : combinational D-stage read ports
//   trace_valid/trace_ready                : trace FIFO handshake
//   trace_pc/trace_reg/trace_data          : trace FIFO head entry
//   trace_count, trace_overflow            : FIFO occupancy, sticky drop flag
interface grf_writeback_sink_if #(
    parameter int unsigned TRACE_AW = 2
);
    logic                RegWrite_W;
    logic [4:0]          WriteReg_W;
    logic [31:0]         Result_W;
    logic [31:0]         PC_W;
    logic [4:0]          RA1;
    logic [4:0]          RA2;
    logic [31:0]         RD1;
    logic [31:0]         RD2;
    logic                trace_valid;
    logic                trace_ready;
    logic [31:0]         trace_pc;
    logic [4:0]          trace_reg;
    logic [31:0]         trace_data;
    logic [TRACE_AW:0]   trace_count;
    logic                trace_overflow;

    modport master (
        output RegWrite_W, WriteReg_W, Result_W, PC_W, RA1, RA2, trace_ready,
        input  RD1, RD2, trace_valid, trace_pc, trace_reg, trace_data,
               trace_count, trace_overflow
    );

    modport slave (
        input  RegWrite_W, WriteReg_W, Result_W, PC_W, RA1, RA2, trace_ready,
        output RD1, RD2, trace_valid, trace_pc, trace_reg, trace_data,
               trace_count, trace_overflow
    );
endinterface

// File: rtl/grf_writeback_sink.sv
// General register file terminating the W-stage writeback of the MIPS pipeline.
// Commits W-stage results into a 32x32 array ($0 hard-wired to zero), serves
// two combinational read ports with same-cycle W->D bypass, and queues every
// committed write in a small trace FIFO drained over a valid/ready port.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   wb    : grf_writeback_sink_if.slave (writeback, read ports, trace port)
module grf_writeback_sink #(
    parameter int unsigned TRACE_DEPTH = 4,
    parameter int unsigned TRACE_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    grf_writeback_sink_if.slave   wb
);

    localparam logic [TRACE_AW:0] FULL_COUNT = (TRACE_AW + 1)'(TRACE_DEPTH);

    logic [31:0]         regs [32];
    logic [31:0]         fifo_pc   [TRACE_DEPTH];
    logic [4:0]          fifo_reg  [TRACE_DEPTH];
    logic [31:0]         fifo_data [TRACE_DEPTH];
    logic [TRACE_AW-1:0] wr_ptr;
    logic [TRACE_AW-1:0] rd_ptr;
    logic [TRACE_AW:0]   count;
    logic                overflow;

    logic commit;
    logic full;
    logic not_empty;
    logic do_pop;
    logic do_push;
    logic drop;

    assign commit    = wb.RegWrite_W && (wb.WriteReg_W != 5'd0);
    assign full      = (count == FULL_COUNT);
    assign not_empty = (count != '0);
    assign do_pop    = not_empty && wb.trace_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push   = commit && (!full || do_pop);
    assign drop      = commit && full && !do_pop;

    // Register array; entry 0 is never written and never read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb.WriteReg_W] <= wb.Result_W;
        end
    end

    // Read ports with W->D bypass so the D stage never sees the write latency.
    always_comb begin
        if (wb.RA1 == 5'd0) begin
            wb.RD1 = '0;
        end else if (commit && (wb.WriteReg_W == wb.RA1)) begin
            wb.RD1 = wb.Result_W;
        end else begin
            wb.RD1 = regs[wb.RA1];
        end
    end

    always_comb begin
        if (wb.RA2 == 5'd0) begin
            wb.RD2 = '0;
        end else if (commit && (wb.WriteReg_W == wb.RA2)) begin
            wb.RD2 = wb.Result_W;
        end else begin
            wb.RD2 = regs[wb.RA2];
        end
    end

    // Trace storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_pc[wr_ptr]   <= wb.PC_W;
            fifo_reg[wr_ptr]  <= wb.WriteReg_W;
            fifo_data[wr_ptr] <= wb.Result_W;
        end
    end

    // Pointers wrap naturally since TRACE_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign wb.trace_valid    = not_empty;
    assign wb.trace_count    = count;
    assign wb.trace_overflow = overflow;
    assign wb.trace_pc       = not_empty ? fifo_pc[rd_ptr]   : '0;
    assign wb.trace_reg      = not_empty ? fifo_reg[rd_ptr]  : '0;
    assign wb.trace_data     = not_empty ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_grf_writeback_sink.sv
// Directed testbench for grf_writeback_sink (TRACE_DEPTH = 4).
module tb_grf_writeback_sink;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    grf_writeback_sink_if #(.TRACE_AW(2)) wb ();

    grf_writeback_sink #(
        .TRACE_DEPTH(4),
        .TRACE_AW(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb(wb)
    );

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb.RegWrite_W  = 1'b0;
        wb.WriteReg_W  = 5'd0;
        wb.Result_W    = 32'd0;
        wb.PC_W        = 32'd0;
        wb.RA1         = 5'd0;
        wb.RA2         = 5'd0;
        wb.trace_ready = 1'b0;
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        tick();
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        tick();
        for (int r = 0; r < 32; r++) begin
            wb.RA1 = 5'(r);
            wb.RA2 = 5'(31 - r);
            #1;
            checks++;
            if (wb.RD1 !== 32'd0 || wb.RD2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_read r=%0d: RD1=%h RD2=%h expected 0", r, wb.RD1, wb.RD2);
            end
        end
        checks++;
        if (wb.trace_valid !== 1'b0 || wb.trace_count !== 3'd0 || wb.trace_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_trace: valid=%b count=%0d ovf=%b expected 0 0 0",
                     wb.trace_valid, wb.trace_count, wb.trace_overflow);
        end
        checks++;
        if (wb.trace_pc !== 32'd0 || wb.trace_reg !== 5'd0 || wb.trace_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_head: pc=%h reg=%0d data=%h expected zeros",
                     wb.trace_pc, wb.trace_reg, wb.trace_data);
        end
    endtask

    task automatic test_write_bypass();
        tick();
        wb.RegWrite_W = 1'b1;
        wb.WriteReg_W = 5'd8;
        wb.Result_W   = 32'h1234_5678;
        wb.PC_W       = 32'h0000_3000;
        wb.RA1        = 5'd8;
        wb.RA2        = 5'd8;
        #1;
        checks++;
        if (wb.RD1 !== 32'h1234_5678 || wb.RD2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL bypass: RD1=%h RD2=%h expected 12345678", wb.RD1, wb.RD2);
        end
        checks++;
        if (wb.trace_count !== 3'd0) begin
            errors++;
            $display("FAIL first_word_latency: count=%0d expected 0", wb.trace_count);
        end
        tick();
        wb.RegWrite_W = 1'b0;
        wb.Result_W   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (wb.RD1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL array_read: RD1=%h expected 12345678", wb.RD1);
        end
        checks++;
        if (wb.trace_valid !== 1'b1 || wb.trace_pc !== 32'h3000 || wb.trace_reg !== 5'd8 ||
            wb.trace_data !== 32'h1234_5678 || wb.trace_count !== 3'd1) begin
            errors++;
            $display("FAIL trace_head: valid=%b pc=%h reg=%0d data=%h count=%0d expected 1 3000 8 12345678 1",
                     wb.trace_valid, wb.trace_pc, wb.trace_reg, wb.trace_data, wb.trace_count);
        end
        wb.trace_ready = 1'b1;
        tick();
        wb.trace_ready = 1'b0;
        #1;
        checks++;
        if (wb.trace_valid !== 1'b0 || wb.trace_count !== 3'd0) begin
            errors++;
            $display("FAIL pop_single: valid=%b count=%0d expected 0 0", wb.trace_valid, wb.trace_count);
        end
    endtask

    task automatic test_zero_write();
        tick();
        wb.RegWrite_W = 1'b1;
        wb.WriteReg_W = 5'd0;
        wb.Result_W   = 32'hFFFF_FFFF;
        wb.RA1        = 5'd0;
        wb.RA2        = 5'd0;
        wb.trace_ready = 1'b1;
        #1;
        checks++;
        if (wb.RD1 !== 32'd0 || wb.RD2 !== 32'd0) begin
            errors++;
            $display("FAIL zero_bypass: RD1=%h RD2=%h expected 0", wb.RD1, wb.RD2);
        end
        tick();
        wb.RegWrite_W  = 1'b0;
        wb.trace_ready = 1'b0;
        #1;
        checks++;
        if (wb.RD1 !== 32'd0 || wb.trace_count !== 3'd0 || wb.trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_write: RD1=%h count=%0d valid=%b expected 0 0 0",
                     wb.RD1, wb.trace_count, wb.trace_valid);
        end
        // No bypass without RegWrite_W even when the address matches.
        wb.WriteReg_W = 5'd8;
        wb.Result_W   = 32'hDEAD_BEEF;
        wb.RA1        = 5'd8;
        #1;
        checks++;
        if (wb.RD1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL no_bypass_when_disabled: RD1=%h expected 12345678", wb.RD1);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            wb.RegWrite_W = 1'b1;
            wb.WriteReg_W = 5'(i);
            wb.Result_W   = 32'h100 + 32'(i);
            wb.PC_W       = 32'h4000 + 32'(4 * i);
        end
        tick();
        idle_inputs();
        wb.RA1 = 5'd5;
        wb.RA2 = 5'd4;
        #1;
        checks++;
        if (wb.trace_count !== 3'd4 || wb.trace_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state: count=%0d ovf=%b expected 4 1", wb.trace_count, wb.trace_overflow);
        end
        checks++;
        if (wb.RD1 !== 32'h105 || wb.RD2 !== 32'h104) begin
            errors++;
            $display("FAIL overflow_regs: RD1=%h RD2=%h expected 105 104", wb.RD1, wb.RD2);
        end
        wb.trace_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (wb.trace_valid !== 1'b1 || wb.trace_reg !== 5'(i) ||
                wb.trace_data !== 32'h100 + 32'(i) || wb.trace_pc !== 32'h4000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: valid=%b reg=%0d data=%h pc=%h expected 1 %0d %h %h",
                         i, wb.trace_valid, wb.trace_reg, wb.trace_data, wb.trace_pc,
                         i, 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
            end
            tick();
        end
        wb.trace_ready = 1'b0;
        #1;
        checks++;
        if (wb.trace_valid !== 1'b0 || wb.trace_count !== 3'd0 || wb.trace_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drained: valid=%b count=%0d ovf=%b expected 0 0 1",
                     wb.trace_valid, wb.trace_count, wb.trace_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            wb.RegWrite_W = 1'b1;
            wb.WriteReg_W = 5'(i);
            wb.Result_W   = 32'h200 + 32'(i);
            wb.PC_W       = 32'h5000 + 32'(4 * i);
        end
        tick();
        wb.WriteReg_W  = 5'd9;
        wb.Result_W    = 32'h909;
        wb.PC_W        = 32'h5100;
        wb.trace_ready = 1'b1;
        #1;
        checks++;
        if (wb.trace_count !== 3'd4 || wb.trace_reg !== 5'd1) begin
            errors++;
            $display("FAIL full_before: count=%0d head=%0d expected 4 1", wb.trace_count, wb.trace_reg);
        end
        tick();
        wb.RegWrite_W  = 1'b0;
        wb.trace_ready = 1'b0;
        #1;
        checks++;
        if (wb.trace_count !== 3'd4 || wb.trace_overflow !== 1'b0 || wb.trace_reg !== 5'd2) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d ovf=%b head=%0d expected 4 0 2",
                     wb.trace_count, wb.trace_overflow, wb.trace_reg);
        end
        wb.trace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [4:0]  exp_reg;
            logic [31:0] exp_data;
            exp_reg  = (k == 3) ? 5'd9 : 5'(k + 2);
            exp_data = (k == 3) ? 32'h909 : 32'h200 + 32'(k + 2);
            #1;
            checks++;
            if (wb.trace_valid !== 1'b1 || wb.trace_reg !== exp_reg || wb.trace_data !== exp_data) begin
                errors++;
                $display("FAIL full_drain[%0d]: valid=%b reg=%0d data=%h expected 1 %0d %h",
                         k, wb.trace_valid, wb.trace_reg, wb.trace_data, exp_reg, exp_data);
            end
            tick();
        end
        wb.trace_ready = 1'b0;
        #1;
        checks++;
        if (wb.trace_valid !== 1'b0 || wb.trace_count !== 3'd0) begin
            errors++;
            $display("FAIL full_drained: valid=%b count=%0d expected 0 0", wb.trace_valid, wb.trace_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick();
        wb.RegWrite_W = 1'b1;
        wb.WriteReg_W = 5'd10;
        wb.Result_W   = 32'hAAAA_0010;
        wb.PC_W       = 32'h6000;
        tick();
        wb.WriteReg_W  = 5'd11;
        wb.Result_W    = 32'hBBBB_0011;
        wb.PC_W        = 32'h6004;
        wb.trace_ready = 1'b1;
        wb.RA1         = 5'd10;
        wb.RA2         = 5'd10;
        #1;
        checks++;
        if (wb.RD1 !== 32'hAAAA_0010 || wb.RD2 !== wb.RD1) begin
            errors++;
            $display("FAIL same_reg_ports: RD1=%h RD2=%h expected aaaa0010 both", wb.RD1, wb.RD2);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (wb.trace_count !== 3'd1 || wb.trace_reg !== 5'd11 || wb.trace_pc !== 32'h6004) begin
            errors++;
            $display("FAIL push_pop_nonfull: count=%0d reg=%0d pc=%h expected 1 11 6004",
                     wb.trace_count, wb.trace_reg, wb.trace_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        wb.RegWrite_W = 1'b1;
        wb.WriteReg_W = 5'd7;
        wb.Result_W   = 32'hA5A5_A5A5;
        wb.PC_W       = 32'h7000;
        tick();
        wb.WriteReg_W = 5'd3;
        wb.Result_W   = 32'h3;
        tick();
        wb.WriteReg_W = 5'd4;
        wb.Result_W   = 32'h4;
        tick();
        wb.RegWrite_W = 1'b0;
        wb.RA1        = 5'd7;
        wb.RA2        = 5'd7;
        #1;
        checks++;
        if (wb.RD1 !== 32'hA5A5_A5A5 || wb.RD2 !== 32'hA5A5_A5A5 || wb.trace_count !== 3'd3) begin
            errors++;
            $display("FAIL async_pre: RD1=%h RD2=%h count=%0d expected a5a5a5a5 a5a5a5a5 3",
                     wb.RD1, wb.RD2, wb.trace_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (wb.RD1 !== 32'd0 || wb.RD2 !== 32'd0 || wb.trace_valid !== 1'b0 ||
            wb.trace_count !== 3'd0 || wb.trace_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: RD1=%h RD2=%h valid=%b count=%0d data=%h expected all 0",
                     wb.RD1, wb.RD2, wb.trace_valid, wb.trace_count, wb.trace_data);
        end
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (wb.RD1 !== 32'd0 || wb.trace_count !== 3'd0) begin
            errors++;
            $display("FAIL async_after: RD1=%h count=%0d expected 0 0", wb.RD1, wb.trace_count);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_bypass();
        test_zero_write();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
